// File: rtl/tx_clock_pkg.sv
// tx_clock_pkg: shared state encoding, change counter width and sizing helper
// for the TX clock controller.
package tx_clock_pkg;

   localparam int CC_W = 16;

   typedef enum logic [1:0] {IDLE, PRE, SWITCH, POST} state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a > b ? a : b;
      return m > c ? m : c;
   endfunction

endpackage

// File: rtl/clock_mux_n.sv
// clock_mux_n: glitch-free N-way clock mux; each lane enables only after every
// other lane has gated itself off, with the enable retimed in its own clock domain.
module clock_mux_n #(
   parameter int NUM_SPEEDS = 3
) (
   input  logic                  reset,
   input  logic [NUM_SPEEDS-1:0] clk_in,
   input  logic [NUM_SPEEDS-1:0] sel,
   output logic                  clk_out
);

   logic [NUM_SPEEDS-1:0] en;

   for (genvar i = 0; i < NUM_SPEEDS; i++) begin : g_lane
      logic [1:0] s;
      logic       e;
      logic       req;
      assign req = sel[i] & ~|(en & ~(NUM_SPEEDS'(1) << i));
      always_ff @(posedge clk_in[i] or posedge reset)
         if (reset) s <= '0;
         else s <= {s[0], req};
      // Enable changes on the falling edge so the gated lane is low when it flips.
      always_ff @(negedge clk_in[i] or posedge reset)
         if (reset) e <= 1'b0;
         else e <= s[1];
      assign en[i] = e;
   end

   assign clk_out = |(en & clk_in);

endmodule

// File: rtl/synchronizer.sv
// synchronizer: DEPTH-stage flop chain bringing a WIDTH-bit asynchronous bus into clk.
module synchronizer #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] st [DEPTH];

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) st[i] <= '0;
      end else begin
         st[0] <= d;
         for (int i = 1; i < DEPTH; i++) st[i] <= st[i-1];
      end

   assign q = st[DEPTH-1];

endmodule

// File: rtl/tx_clock_controller.sv
// tx_clock_controller: follows the stabilized RX speed/link, switching the TX clock
// only while reset_tx is held. Macro TX_CLKCTRL_LINKDOWN_HOLD_EN holds reset_tx in IDLE while link is down.
module tx_clock_controller
   import tx_clock_pkg::*;
#(
   parameter int NUM_SPEEDS     = 3,
   parameter int SYNC_LEN       = 3,
   parameter int STAB_LEN       = 16,
   parameter int PRE_CYCLES     = 100,
   parameter int POST_CYCLES    = 100,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_SPEEDS-1:0] clk_speed,
   input  logic [NUM_SPEEDS-1:0] rx_speed,
   input  logic                  rx_link_up,
   output logic [NUM_SPEEDS-1:0] tx_speed,
   output logic                  clk_tx,
   output logic                  reset_tx,
   output logic                  link_up,
   output logic                  changing,
   output logic                  timeout_err,
   output logic [CC_W-1:0]       change_count
);

   localparam int CW = $clog2(max3(PRE_CYCLES, POST_CYCLES, TIMEOUT_CYCLES) + 1);
   localparam int W  = NUM_SPEEDS + 1;

   logic [W-1:0]        rx_sync, stable, newest;
   logic [STAB_LEN-1:0] sh [W];
   state_t              state, next_state;
   logic [CW-1:0]       cnt, cnt_next;
   logic                valid, change, commit, timeout_hit, hold;

   synchronizer #(.WIDTH(W), .DEPTH(SYNC_LEN)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     ({rx_link_up, rx_speed}),
      .q     (rx_sync)
   );

   always_ff @(posedge clk or posedge reset)
      if (reset) for (int i = 0; i < W; i++) sh[i] <= '0;
      else for (int i = 0; i < W; i++) sh[i] <= {sh[i][STAB_LEN-2:0], rx_sync[i]};

   for (genvar i = 0; i < W; i++) begin : g_stab
      assign newest[i] = sh[i][0];
      assign stable[i] = &sh[i] | ~|sh[i];
   end

   assign valid       = &stable && $onehot(newest[NUM_SPEEDS-1:0]);
   assign change      = {link_up, tx_speed} != newest;
   assign commit      = state == SWITCH && valid;
   assign timeout_hit = state == SWITCH && !valid && cnt_next == CW'(TIMEOUT_CYCLES);

`ifdef TX_CLKCTRL_LINKDOWN_HOLD_EN
   assign hold = commit ? !newest[NUM_SPEEDS] : !link_up;
`else
   assign hold = 1'b0;
`endif

   // In SWITCH the counter is reused as the wait-for-valid timer, starting from 0 left by PRE.
   always_comb begin
      next_state = state;
      cnt_next   = cnt;
      unique case (state)
         IDLE:
            if (valid && change) begin
               next_state = PRE;
               cnt_next   = CW'(PRE_CYCLES);
            end
         PRE:
            if (cnt == '0) next_state = SWITCH;
            else cnt_next = cnt - 1'b1;
         SWITCH:
            if (valid) begin
               next_state = POST;
               cnt_next   = CW'(POST_CYCLES);
            end else if (cnt != CW'(TIMEOUT_CYCLES)) cnt_next = cnt + 1'b1;
         POST:
            if (cnt != '0) cnt_next = cnt - 1'b1;
            else if (valid && change) begin
               next_state = PRE;
               cnt_next   = CW'(PRE_CYCLES);
            end else if (valid) next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state        <= PRE;
         cnt          <= CW'(PRE_CYCLES);
         reset_tx     <= 1'b1;
         changing     <= 1'b1;
         tx_speed     <= '0;
         link_up      <= 1'b0;
         timeout_err  <= 1'b0;
         change_count <= '0;
      end else begin
         state        <= next_state;
         cnt          <= cnt_next;
         reset_tx     <= next_state != IDLE || hold;
         changing     <= next_state != IDLE;
         if (commit) {link_up, tx_speed} <= newest;
         timeout_err  <= timeout_err | timeout_hit;
         change_count <= change_count + CC_W'(commit && change_count != '1);
      end

   clock_mux_n #(.NUM_SPEEDS(NUM_SPEEDS)) u_mux (
      .reset   (reset),
      .clk_in  (clk_speed),
      .sel     (tx_speed),
      .clk_out (clk_tx)
   );

endmodule

// File: tb/tb_tx_clock_controller.sv
// tb_tx_clock_controller: directed scenarios checked every cycle against a
// window-based behavioural model, plus hand-computed literal expectations.
module tb_tx_clock_controller;

   localparam int NS   = 3;
   localparam int SYNC = 3;
   localparam int STAB = 8;
   localparam int PRE  = 10;
   localparam int POST = 12;
   localparam int TO   = 64;
`ifdef TX_CLKCTRL_LINKDOWN_HOLD_EN
   localparam bit HOLD = 1'b1;
`else
   localparam bit HOLD = 1'b0;
`endif

   logic          clk = 1'b0, reset = 1'b1;
   logic          cs0 = 1'b0, cs1 = 1'b0, cs2 = 1'b0;
   logic [NS-1:0] clk_speed, rx_speed = '0, tx_speed;
   logic          rx_link_up = 1'b0, clk_tx, reset_tx, link_up, changing, timeout_err;
   logic [15:0]   change_count;

   int checks = 0, errors = 0;

   assign clk_speed = {cs2, cs1, cs0};
   always #5  clk = ~clk;
   always #23 cs0 = ~cs0;
   always #13 cs1 = ~cs1;
   always #7  cs2 = ~cs2;

   tx_clock_controller #(
      .NUM_SPEEDS(NS), .SYNC_LEN(SYNC), .STAB_LEN(STAB),
      .PRE_CYCLES(PRE), .POST_CYCLES(POST), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .reset(reset), .clk_speed(clk_speed), .rx_speed(rx_speed),
      .rx_link_up(rx_link_up), .tx_speed(tx_speed), .clk_tx(clk_tx), .reset_tx(reset_tx),
      .link_up(link_up), .changing(changing), .timeout_err(timeout_err),
      .change_count(change_count)
   );

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the controller only ever sees the input as captured SYNC edges ago,
   // and trusts it once the last STAB such samples are identical and one-hot.
   logic [3:0] hist[$];
   int         m_phase, m_left, m_wait, m_cc;
   logic [2:0] m_tx;
   logic       m_link, m_err;

   task automatic m_init();
      hist.delete();
      for (int j = 0; j < SYNC + STAB; j++) hist.push_back(4'h0);
      m_phase = 1; m_left = PRE; m_wait = 0; m_cc = 0;
      m_tx = '0; m_link = 1'b0; m_err = 1'b0;
   endtask

   function automatic bit m_valid();
      logic [3:0] w;
      w = hist[SYNC];
      for (int j = 1; j < STAB; j++) if (hist[SYNC+j] != w) return 1'b0;
      return $onehot(w[2:0]);
   endfunction

   task automatic m_step();
      bit         v, ch;
      logic [3:0] w;
      v  = m_valid();
      w  = hist[SYNC];
      ch = {m_link, m_tx} != w;
      if (m_phase == 0) begin
         if (v && ch) begin m_phase = 1; m_left = PRE; end
      end else if (m_phase == 1) begin
         if (m_left == 0) begin m_phase = 2; m_wait = 0; end
         else m_left--;
      end else if (m_phase == 2) begin
         if (v) begin
            {m_link, m_tx} = w;
            m_phase = 3; m_left = POST;
            if (m_cc < 65535) m_cc++;
         end else begin
            if (m_wait < TO) m_wait++;
            if (m_wait == TO) m_err = 1'b1;
         end
      end else begin
         if (m_left > 0) m_left--;
         else if (v && ch) begin m_phase = 1; m_left = PRE; end
         else if (v) m_phase = 0;
      end
      hist.push_front({rx_link_up, rx_speed});
      void'(hist.pop_back());
   endtask

   initial begin
      m_init();
      forever begin
         @(posedge clk or posedge reset);
         if (reset) m_init();
         else m_step();
      end
   end

   initial forever begin
      @(negedge clk);
      chk("tx_speed", tx_speed, m_tx);
      chk("link_up", link_up, m_link);
      chk("changing", changing, m_phase != 0);
      chk("reset_tx", reset_tx, m_phase != 0 || (HOLD && !m_link));
      chk("timeout_err", timeout_err, m_err);
      chk("change_count", change_count, m_cc);
   end

   task automatic wait_busy();
      int n = 0;
      while (!changing && n < 300) begin @(negedge clk); n++; end
      chk("wait_busy", changing, 1);
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      do begin @(negedge clk); n++; end while (changing && n < 400);
      chk("wait_idle", changing, 0);
   endtask

   task automatic wait_tx(input logic [2:0] v);
      int n = 0;
      while (tx_speed != v && n < 300) begin @(negedge clk); n++; end
      chk("wait_tx", tx_speed, v);
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_reset_tx"}, reset_tx, 1);
      chk({tag, "_changing"}, changing, 1);
      chk({tag, "_tx_speed"}, tx_speed, 0);
      chk({tag, "_link_up"}, link_up, 0);
      chk({tag, "_timeout_err"}, timeout_err, 0);
      chk({tag, "_change_count"}, change_count, 0);
   endtask

   initial begin
      int n;
      rx_speed   = 3'b100;
      rx_link_up = 1'b1;
      repeat (3) @(negedge clk);
      chk_reset_values("por");
      reset = 1'b0;
      wait_idle(n);
      chk("bringup_hold_len", n >= PRE + POST, 1);
      chk("bringup_tx_speed", tx_speed, 3'b100);
      chk("bringup_count", change_count, 1);
      chk("bringup_reset_tx", reset_tx, 0);

      rx_speed = 3'b010;
      wait_busy();
      wait_idle(n);
      chk("switch_tx_speed", tx_speed, 3'b010);
      chk("switch_count", change_count, 2);
      repeat (10) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         @(posedge cs1); #2;
         chk("clk_tx_high", clk_tx, 1);
         @(negedge cs1); #2;
         chk("clk_tx_low", clk_tx, 0);
      end

      @(negedge clk);
      rx_speed = 3'b001;
      repeat (STAB - 2) @(negedge clk);
      rx_speed = 3'b010;
      rx_link_up = 1'b0;
      repeat (STAB - 2) @(negedge clk);
      rx_link_up = 1'b1;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         chk("glitch_reset_tx", reset_tx, 0);
      end
      chk("glitch_count", change_count, 2);

      rx_speed = 3'b001;
      wait_busy();
      rx_speed = 3'b110;
      repeat (PRE + 1 + TO + 10) @(negedge clk);
      chk("timeout_err_set", timeout_err, 1);
      chk("timeout_reset_tx", reset_tx, 1);
      chk("timeout_count", change_count, 2);
      rx_speed = 3'b001;
      wait_idle(n);
      chk("recover_tx_speed", tx_speed, 3'b001);
      chk("recover_timeout_err", timeout_err, 1);
      chk("recover_count", change_count, 3);

      rx_speed = 3'b100;
      wait_tx(3'b100);
      rx_speed = 3'b010;
      n = 0;
      while (tx_speed != 3'b010 && n < 300) begin
         @(negedge clk);
         n++;
         chk("post_rechange_busy", changing, 1);
      end
      chk("post_rechange_tx", tx_speed, 3'b010);
      chk("post_rechange_count", change_count, 5);
      repeat (4) @(negedge clk);
      #2 reset = 1'b1;
      #1 chk_reset_values("mid_post");
      @(negedge clk);
      reset = 1'b0;
      n = 0;
      while (tx_speed == 3'b000 && n < 300) begin @(negedge clk); n++; end
      chk("first_commit_delay", n >= PRE, 1);
      wait_idle(n);
      chk("after_reset_tx", tx_speed, 3'b010);
      chk("after_reset_count", change_count, 1);

      rx_link_up = 1'b0;
      wait_busy();
      wait_idle(n);
      @(negedge clk);
      chk("linkdown_link_up", link_up, 0);
      chk("linkdown_reset_tx", reset_tx, HOLD);
      chk("linkdown_count", change_count, 2);

      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/tx_clock_controller.md
TX_CLOCK_CONTROLLER -- requirements
Module: tx_clock_controller

Interface
REQ-001 SHALL have parameter NUM_SPEEDS, default 3, the number of one-hot speed lanes (bit 0 slowest).
REQ-002 SHALL have parameter SYNC_LEN, default 3, the synchronizer depth.
REQ-003 SHALL have parameter STAB_LEN, default 16, the cycles of agreement required per input; minimum 2.
REQ-004 SHALL have parameter PRE_CYCLES, default 100, the cycles of reset_tx before a clock switch.
REQ-005 SHALL have parameter POST_CYCLES, default 100, the cycles after a switch before reset_tx releases.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 4096, the wait limit for valid inputs in SWITCH.
REQ-007 SHALL have ports: clk  in  1  module clock; reset  in  1  asynchronous active-high reset.
REQ-008 SHALL have ports: clk_speed  in  NUM_SPEEDS  candidate TX clocks, indexed as rx_speed.
REQ-009 SHALL have ports: rx_speed  in  NUM_SPEEDS  one-hot RX speed, unsynchronized; rx_link_up  in  1  RX link, unsynchronized.
REQ-010 SHALL have ports: tx_speed  out  NUM_SPEEDS  committed speed; clk_tx  out  1  muxed TX clock; reset_tx  out  1  TX MAC reset.
REQ-011 SHALL have ports: link_up  out  1  committed link; changing  out  1  transition in progress; timeout_err  out  1  sticky timeout flag; change_count  out  16  committed switches.

Function
REQ-012 SHALL pass rx_speed and rx_link_up through one SYNC_LEN-deep synchronizer into STAB_LEN-bit shift registers per bit.
REQ-013 SHALL define valid as every shift register all-0 or all-1 AND newest speed sample exactly one-hot.
REQ-014 SHALL define change as (committed tx_speed, link_up) != newest stabilized (speed, link).
REQ-015 SHALL implement states IDLE, PRE, SWITCH, POST.
REQ-016 IDLE: on valid && change SHALL load counter with PRE_CYCLES and go to PRE; otherwise stay.
REQ-017 PRE: SHALL decrement counter and go to SWITCH the cycle after counter reaches 0; inputs are ignored.
REQ-018 SWITCH: on valid SHALL commit tx_speed and link_up from the stabilized inputs, load counter with POST_CYCLES, go to POST, and increment change_count, saturating at 16'hFFFF.
REQ-019 SWITCH: while not valid SHALL count wait cycles; on reaching TIMEOUT_CYCLES SHALL set timeout_err and remain in SWITCH.
REQ-020 POST: SHALL decrement counter to 0; then on valid && change SHALL reload PRE_CYCLES and go to PRE; on valid && !change SHALL go to IDLE; while invalid SHALL hold.
REQ-021 reset_tx and changing SHALL be registered and equal 1 in the same cycle state is PRE, SWITCH or POST, and 0 in IDLE.
REQ-022 tx_speed SHALL change only in SWITCH, so a clock switch happens only under reset_tx.
REQ-023 clk_tx SHALL be a glitch-free mux of clk_speed selected by tx_speed; all-zero tx_speed SHALL give constant 0.
REQ-024 Counter widths SHALL be $clog2(max(PRE_CYCLES, POST_CYCLES, TIMEOUT_CYCLES)+1).
REQ-025 Sub-STAB_LEN glitches on any input SHALL NOT change state.

Reset
REQ-026 When reset is asserted, SHALL set asynchronously: state=PRE, counter=PRE_CYCLES, reset_tx=1, changing=1, tx_speed=0, link_up=0, timeout_err=0, change_count=0.
REQ-027 Reset asserted mid-operation SHALL abort any state; the first post-reset commit SHALL follow PRE_CYCLES.
REQ-028 timeout_err SHALL clear only on reset.

Configuration
REQ-029 With macro TX_CLKCTRL_LINKDOWN_HOLD_EN defined, reset_tx SHALL also be 1 in IDLE whenever link_up=0; undefined, reset_tx SHALL follow REQ-021 only.

Structure
REQ-030 Package tx_clock_pkg SHALL hold the state enum and the change_count width constant.
REQ-031 SHALL instantiate the existing synchronizer (WIDTH=NUM_SPEEDS+1) and one sub-module clock_mux_n parametrised by NUM_SPEEDS.

Verification
REQ-032 Reset release, rx_speed=3'b100, link up -> reset_tx high at least PRE_CYCLES+POST_CYCLES, then tx_speed=3'b100, change_count=1, reset_tx=0.
REQ-033 From IDLE at 3'b100, switch rx_speed to 3'b010 -> PRE, SWITCH, POST sequence, clk_tx at clk_speed[1] rate, change_count=2.
REQ-034 rx_speed glitch of STAB_LEN-2 cycles -> no state change, reset_tx stays 0.
REQ-035 rx_speed=3'b110 held in SWITCH for TIMEOUT_CYCLES+10 -> timeout_err=1, reset_tx=1; then 3'b001 -> commit with timeout_err still 1.
REQ-036 Speed change during POST -> return to PRE; reset asserted mid-POST -> outputs immediately at REQ-026 values.
REQ-037 With TX_CLKCTRL_LINKDOWN_HOLD_EN defined, drop link in IDLE -> after a full cycle, link_up=0 and reset_tx=1.
